bus_timer: RTL and testbench

Memory-mapped 16-bit down-counter timer that acts as a responder on the cpu6502 bus. It decodes a 4-byte register window, accepts CPU stores, returns CPU loads and drives the active-low `irq` input of the CPU on underflow. In system benches it sits beside the ROM/RAM models: its `rdata` is muxed onto the CPU `idata` under `sel`, and its `irq_n` connects to the CPU `irq`.

---
 rtl/bus_timer.sv | 207 ++++++++++++++++++++
 tb/tb_bus_timer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bus_timer.sv
// bus_timer: memory-mapped 16-bit down-counter timer on the cpu6502 bus.
// Four-byte register window at BASE..BASE+3 (LATCH lo/hi, CTRL, STATUS).
// Counting is paced by falling edges of the CPU phi2 clock (clk2), divided by
// PRESCALE; underflow sets UF and, with IE set, pulls irq_n low.
// Optional feature macro: BUS_TIMER_SNAPSHOT_EN. When defined, a read of
// offset 0 captures COUNT[15:8] into SNAP so that a following read of
// offset 1 returns a high byte coherent with the low byte already read.
module bus_timer #(
  parameter logic [15:0] BASE     = 16'hD000,
  parameter int unsigned PRESCALE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        rw,
  input  logic        clk2,
  output logic        sel,
  output logic [7:0]  rdata,
  output logic        irq_n
);

  // Prescaler terminal value; PRESCALE is limited to 1..256, so this fits 8 bits.
  localparam logic [7:0] PRE_LAST = 8'(PRESCALE - 1);

  // Register offsets inside the window.
  typedef enum logic [1:0] {
    OFF_LO     = 2'd0,
    OFF_HI     = 2'd1,
    OFF_CTRL   = 2'd2,
    OFF_STATUS = 2'd3
  } reg_off_t;

  logic        clk2_q;
  logic        rise;
  logic        fall;
  logic [1:0]  off;
  logic        wr_strobe;
  logic        wr_lat_lo;
  logic        wr_lat_hi;
  logic        wr_ctrl;
  logic        wr_stat;
  logic        tick;
  logic        dec;
  logic        underflow;

  logic [15:0] count;
  logic [15:0] latch;
  logic        en;
  logic        reload;
  logic        ie;
  logic        uf;
  logic [7:0]  pre;

  // Address decode and phi2 edge detection.
  assign sel       = (addr[15:2] == BASE[15:2]);
  assign off       = addr[1:0];
  assign rise      = clk2 & ~clk2_q;
  assign fall      = ~clk2 & clk2_q;

  // CPU stores land at the start of phi2, i.e. on the registered rise.
  assign wr_strobe = rise & ~rw & sel;
  assign wr_lat_lo = wr_strobe & (off == OFF_LO);
  assign wr_lat_hi = wr_strobe & (off == OFF_HI);
  assign wr_ctrl   = wr_strobe & (off == OFF_CTRL);
  assign wr_stat   = wr_strobe & (off == OFF_STATUS);

  // A tick is one enabled phi2 fall; a decrement is every PRESCALE-th tick.
  assign tick      = fall & en;
  assign dec       = tick & (pre == PRE_LAST);
  assign underflow = dec & (count == 16'h0000);

  // Register phi2 on the system clock so its edges can be detected.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk2_q <= 1'b0;
    end else begin
      clk2_q <= clk2;
    end
  end

  // Prescaler: counts ticks, wraps after PRESCALE of them; held at 0 while
  // disabled and restarted whenever a new count is loaded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre <= 8'h00;
    end else if (wr_lat_hi || !en) begin
      pre <= 8'h00;
    end else if (tick) begin
      if (dec) begin
        pre <= 8'h00;
      end else begin
        pre <= pre + 8'd1;
      end
    end
  end

  // LATCH holds the reload value; each half is written from its own offset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      latch <= 16'hFFFF;
    end else begin
      if (wr_lat_lo) begin
        latch[7:0] <= wdata;
      end
      if (wr_lat_hi) begin
        latch[15:8] <= wdata;
      end
    end
  end

  // COUNT: a LATCH_HI write loads it and beats any simultaneous decrement;
  // at zero it either reloads from LATCH or stays at zero (never wraps).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 16'h0000;
    end else if (wr_lat_hi) begin
      count <= {wdata, latch[7:0]};
    end else if (dec) begin
      if (count != 16'h0000) begin
        count <= count - 16'd1;
      end else if (reload) begin
        count <= latch;
      end
    end
  end

  // CTRL: one-shot underflow clears EN, a LATCH_HI write sets it, and an
  // explicit CTRL write overrides both because it is assigned last.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en     <= 1'b0;
      reload <= 1'b0;
      ie     <= 1'b0;
    end else begin
      if (underflow && !reload) begin
        en <= 1'b0;
      end
      if (wr_lat_hi) begin
        en <= 1'b1;
      end
      if (wr_ctrl) begin
        en     <= wdata[0];
        reload <= wdata[1];
        ie     <= wdata[2];
      end
    end
  end

  // UF: write-one-to-clear, but a coincident underflow wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uf <= 1'b0;
    end else begin
      if (wr_stat && wdata[0]) begin
        uf <= 1'b0;
      end
      if (underflow) begin
        uf <= 1'b1;
      end
    end
  end

  // Registered active-low interrupt, level-held while UF and IE are both set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_n <= 1'b1;
    end else begin
      irq_n <= ~(uf & ie);
    end
  end

`ifdef BUS_TIMER_SNAPSHOT_EN
  logic [7:0] snap;
  logic [7:0] hi_byte;

  // Capture the high byte when the CPU samples the low byte (end of phi2).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap <= 8'h00;
    end else if (fall && rw && sel && (off == OFF_LO)) begin
      snap <= count[15:8];
    end
  end

  assign hi_byte = snap;
`else
  logic [7:0] hi_byte;

  assign hi_byte = count[15:8];
`endif

  // Combinational read mux; returns zero outside the window.
  always_comb begin
    rdata = 8'h00;
    if (sel) begin
      case (off)
        OFF_LO:     rdata = count[7:0];
        OFF_HI:     rdata = hi_byte;
        OFF_CTRL:   rdata = {5'b00000, ie, reload, en};
        OFF_STATUS: rdata = {7'b0000000, uf};
        default:    rdata = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer: directed bench for bus_timer with a scoreboard.
// Each emulated CPU bus cycle pushes its expected response; a monitor pops
// one entry per phi2 fall (the CPU sample point) and compares.
module tb_bus_timer;

  localparam logic [15:0] BASE = 16'hD000;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        rw;
  logic        clk2;
  logic        sel;
  logic [7:0]  rdata;
  logic        irq_n;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    bit         chk_rd;
    logic [7:0] rd;
    bit         chk_sel;
    logic       sel;
    bit         chk_irq;
    logic       irq;
    bit         chk_edge;
  } exp_t;

  exp_t sb[$];

  bus_timer #(
    .BASE(BASE),
    .PRESCALE(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .addr(addr),
    .wdata(wdata),
    .rw(rw),
    .clk2(clk2),
    .sel(sel),
    .rdata(rdata),
    .irq_n(irq_n)
  );

  // System clock.
  always #5 clk = ~clk;

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %02h, expected %02h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input string n, input bit cr, input logic [7:0] rd,
                              input bit cs, input logic s, input bit ci,
                              input logic irq, input bit ce);
    exp_t e;
    e.name = n; e.chk_rd = cr; e.rd = rd; e.chk_sel = cs; e.sel = s;
    e.chk_irq = ci; e.irq = irq; e.chk_edge = ce;
    return e;
  endfunction

  // One CPU bus cycle: address phase with clk2 low, 2 clk of clk2 high, then fall.
  task automatic applyStimulus(input logic [15:0] a, input logic r, input logic [7:0] d, input exp_t e);
    @(negedge clk);
    addr  = a;
    rw    = r;
    wdata = d;
    @(negedge clk);
    clk2 = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    @(negedge clk);
    clk2 = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd_reg(input logic [1:0] off, input string n, input logic [7:0] v,
                        input bit ci = 0, input logic irq = 1'b1, input bit ce = 0);
    applyStimulus(BASE + {14'd0, off}, 1'b1, 8'h00, mk(n, 1, v, 1, 1'b1, ci, irq, ce));
  endtask

  task automatic wr_reg(input logic [1:0] off, input logic [7:0] v, input string n,
                        input bit ci = 0, input logic irq = 1'b1, input bit ce = 0);
    applyStimulus(BASE + {14'd0, off}, 1'b0, v, mk(n, 0, 8'h00, 1, 1'b1, ci, irq, ce));
  endtask

  task automatic bus_out(input logic [15:0] a, input logic r, input logic [7:0] d, input string n);
    applyStimulus(a, r, d, mk(n, 1, 8'h00, 1, 1'b0, 0, 1'b1, 0));
  endtask

  // Monitor: at every phi2 fall, pop the expectation for that bus cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk2);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_fall: got fall with empty scoreboard, expected none");
      end else begin
        e = sb.pop_front();
        if (e.chk_rd)  checkOutput({e.name, ".rdata"}, rdata, e.rd);
        if (e.chk_sel) checkOutput({e.name, ".sel"}, {7'd0, sel}, {7'd0, e.sel});
        if (e.chk_irq) checkOutput({e.name, ".irq_n"}, {7'd0, irq_n}, {7'd0, e.irq});
        if (e.chk_edge) begin
          @(negedge clk);
          checkOutput({e.name, ".irq_n_t1"}, {7'd0, irq_n}, 8'h01);
          @(negedge clk);
          checkOutput({e.name, ".irq_n_t2"}, {7'd0, irq_n}, 8'h00);
        end
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    addr  = 16'h0000;
    wdata = 8'h00;
    rw    = 1'b1;
    clk2  = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] reset values");
    rd_reg(2'd2, "rst_ctrl", 8'h00, 1, 1'b1);
    rd_reg(2'd3, "rst_status", 8'h00);
    rd_reg(2'd0, "rst_count_lo", 8'h00);
    rd_reg(2'd1, "rst_count_hi", 8'h00);

    $display("[TB] one-shot, LATCH=0003");
    wr_reg(2'd2, 8'h04, "os_ctrl");
    wr_reg(2'd0, 8'h03, "os_lat_lo");
    wr_reg(2'd1, 8'h00, "os_lat_hi");
    rd_reg(2'd0, "os_cnt2", 8'h02);
    rd_reg(2'd0, "os_cnt1", 8'h01);
    rd_reg(2'd3, "os_pre_uf", 8'h00, 1, 1'b1, 1);
    rd_reg(2'd3, "os_status", 8'h01, 1, 1'b0);
    rd_reg(2'd0, "os_count_lo", 8'h00);
    rd_reg(2'd1, "os_count_hi", 8'h00);
    rd_reg(2'd2, "os_ctrl_en_clr", 8'h04);
    wr_reg(2'd3, 8'h00, "os_wr_zero");
    rd_reg(2'd3, "os_status_kept", 8'h01, 1, 1'b0);
    wr_reg(2'd3, 8'h01, "os_clr", 1, 1'b1);
    rd_reg(2'd3, "os_status_clr", 8'h00, 1, 1'b1);

    $display("[TB] auto-reload, LATCH=0002");
    wr_reg(2'd0, 8'h02, "ar_lat_lo");
    wr_reg(2'd1, 8'h00, "ar_lat_hi");
    wr_reg(2'd2, 8'h07, "ar_ctrl");
    rd_reg(2'd3, "ar_pre_uf1", 8'h00, 1, 1'b1, 1);
    rd_reg(2'd3, "ar_uf1", 8'h01, 1, 1'b0);
    wr_reg(2'd3, 8'h01, "ar_clr", 1, 1'b1);
    rd_reg(2'd3, "ar_pre_uf2", 8'h00, 1, 1'b1, 1);
    rd_reg(2'd0, "ar_reload", 8'h02, 1, 1'b0);
    rd_reg(2'd0, "ar_cnt1", 8'h01);

    $display("[TB] clear in underflow cycle");
    wr_reg(2'd3, 8'h01, "col_clr", 1, 1'b1, 1);
    rd_reg(2'd3, "col_uf", 8'h01, 1, 1'b0);
    wr_reg(2'd2, 8'h00, "ar_stop");
    wr_reg(2'd3, 8'h01, "ar_clr2");
    rd_reg(2'd0, "ar_frozen", 8'h01, 1, 1'b1);
    rd_reg(2'd2, "ar_ctrl_off", 8'h00);

    $display("[TB] high-byte read after one decrement");
    wr_reg(2'd0, 8'h01, "sn_lat_lo");
    wr_reg(2'd1, 8'h01, "sn_lat_hi");
    rd_reg(2'd0, "sn_lo", 8'h00);
`ifdef BUS_TIMER_SNAPSHOT_EN
    rd_reg(2'd1, "sn_hi", 8'h01);
`else
    rd_reg(2'd1, "sn_hi", 8'h00);
`endif
    wr_reg(2'd2, 8'h00, "sn_stop");

    $display("[TB] decode boundaries");
    bus_out(BASE + 16'd4, 1'b1, 8'h00, "dec_rd_p4");
    bus_out(BASE - 16'd1, 1'b1, 8'h00, "dec_rd_m1");
    bus_out(BASE + 16'd5, 1'b0, 8'h12, "dec_wr_p5");
    bus_out(BASE + 16'd6, 1'b0, 8'h07, "dec_wr_p6");
    bus_out(BASE - 16'd1, 1'b0, 8'h01, "dec_wr_m1");
    rd_reg(2'd0, "dec_cnt_lo", 8'hFE);
    rd_reg(2'd1, "dec_cnt_hi", 8'h00);
    rd_reg(2'd2, "dec_ctrl", 8'h00);
    rd_reg(2'd3, "dec_status", 8'h00, 1, 1'b1);

    for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    checkOutput("scoreboard_drained", 8'(sb.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
